// File: rtl/mem_requester_if.sv
// mem_requester_if
//   Bundles the client command/data handshakes and the main-memory pin
//   interface used by mem_requester.
//
//   Client side : cmd_valid/cmd_ready/cmd_we/cmd_addr/cmd_len,
//                 wdata/wdata_valid/wdata_ready,
//                 rdata/rdata_valid/rdata_ready
//   Memory side : rd_mem/wr_mem/addr_mem/mem_data_wr/mem_data_rd/ready_mem
//
//   Modports:
//     master - the requester (drives the memory strobes, answers the client)
//     slave  - the environment (client plus memory)
interface mem_requester_if #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 32,
  parameter int LWIDTH = 4
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [AWIDTH-1:0] cmd_addr;
  logic [LWIDTH-1:0] cmd_len;

  logic [DWIDTH-1:0] wdata;
  logic              wdata_valid;
  logic              wdata_ready;

  logic [DWIDTH-1:0] rdata;
  logic              rdata_valid;
  logic              rdata_ready;

  logic              rd_mem;
  logic              wr_mem;
  logic [AWIDTH-1:0] addr_mem;
  logic [DWIDTH-1:0] mem_data_wr;
  logic [DWIDTH-1:0] mem_data_rd;
  logic              ready_mem;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len,
    input  wdata, wdata_valid,
    input  rdata_ready,
    input  mem_data_rd, ready_mem,
    output cmd_ready, wdata_ready,
    output rdata, rdata_valid,
    output rd_mem, wr_mem, addr_mem, mem_data_wr
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_len,
    output wdata, wdata_valid,
    output rdata_ready,
    output mem_data_rd, ready_mem,
    input  cmd_ready, wdata_ready,
    input  rdata, rdata_valid,
    input  rd_mem, wr_mem, addr_mem, mem_data_wr
  );

endinterface

// File: rtl/mem_requester.sv
// mem_requester
//   Initiator-side controller for the word-addressed on-chip main memory.
//   Accepts single or burst read/write commands from a client, issues one
//   memory access at a time, returns read data through a valid/ready
//   handshake and raises a sticky error if memory never signals ready.
//
// Ports:
//   clk    - system clock, all logic on the rising edge
//   reset  - synchronous, active-high reset
//   bus    - mem_requester_if.master: client command / write-data /
//            read-data handshakes and the memory strobe/address/data pins
//   busy   - high whenever the controller is not idle
//   err    - sticky timeout flag, cleared only by reset
module mem_requester #(
  parameter int AWIDTH  = 9,
  parameter int DWIDTH  = 32,
  parameter int LWIDTH  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  mem_requester_if.master   bus,
  output logic              busy,
  output logic              err
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Value the timeout counter holds when the next stalled cycle expires it.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_WD = 2'd1,
    ISSUE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state;
  logic              cur_we;
  logic [LWIDTH-1:0] beat_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic              beat_done;

  // A beat is finished once memory is idle again and, for reads, the data
  // has been handed over. rdata_valid only falls on the handshake, so a low
  // rdata_valid in DONE means the handshake already happened.
  assign beat_done = bus.ready_mem &&
                     (cur_we || !bus.rdata_valid || bus.rdata_ready);

  // All outputs are registered and set up for the state being entered, so
  // the strobes and ready signals line up exactly with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cur_we          <= 1'b0;
      beat_cnt        <= '0;
      tmo_cnt         <= '0;
      busy            <= 1'b0;
      err             <= 1'b0;
      bus.cmd_ready   <= 1'b1;
      bus.wdata_ready <= 1'b0;
      bus.rdata       <= '0;
      bus.rdata_valid <= 1'b0;
      bus.rd_mem      <= 1'b0;
      bus.wr_mem      <= 1'b0;
      bus.addr_mem    <= '0;
      bus.mem_data_wr <= '0;
    end else begin
      // Strobes are single-cycle: only the transition into ISSUE raises one.
      bus.rd_mem <= 1'b0;
      bus.wr_mem <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            cur_we        <= bus.cmd_we;
            bus.addr_mem  <= bus.cmd_addr;
            beat_cnt      <= bus.cmd_len;
            bus.cmd_ready <= 1'b0;
            busy          <= 1'b1;
            if (bus.cmd_we) begin
              state           <= WAIT_WD;
              bus.wdata_ready <= 1'b1;
            end else begin
              state      <= ISSUE;
              bus.rd_mem <= 1'b1;
            end
          end
        end

        WAIT_WD: begin
          if (bus.wdata_valid) begin
            bus.mem_data_wr <= bus.wdata;
            bus.wdata_ready <= 1'b0;
            bus.wr_mem      <= 1'b1;
            state           <= ISSUE;
          end
        end

        ISSUE: begin
          // Memory drove read data on the falling edge inside ISSUE.
          state   <= DONE;
          tmo_cnt <= '0;
          if (!cur_we) begin
            bus.rdata       <= bus.mem_data_rd;
            bus.rdata_valid <= 1'b1;
          end
        end

        DONE: begin
          if (bus.rdata_valid && bus.rdata_ready) begin
            bus.rdata_valid <= 1'b0;
          end

          if (beat_done) begin
            if (beat_cnt == '0) begin
              state         <= IDLE;
              bus.cmd_ready <= 1'b1;
              busy          <= 1'b0;
            end else begin
              beat_cnt     <= beat_cnt - LWIDTH'(1);
              // Natural overflow gives the modulo-2^AWIDTH address wrap.
              bus.addr_mem <= bus.addr_mem + AWIDTH'(1);
              if (cur_we) begin
                state           <= WAIT_WD;
                bus.wdata_ready <= 1'b1;
              end else begin
                state      <= ISSUE;
                bus.rd_mem <= 1'b1;
              end
            end
          end else if (!bus.ready_mem) begin
            if (tmo_cnt == TMO_LAST) begin
              // Memory is stuck: give up on the whole burst, keep the flag.
              err             <= 1'b1;
              bus.rdata_valid <= 1'b0;
              bus.cmd_ready   <= 1'b1;
              busy            <= 1'b0;
              tmo_cnt         <= tmo_cnt + TW'(1);
              state           <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Protocol invariants of the memory and client interfaces.
  a_strobe_excl: assert property (@(posedge clk) disable iff (reset)
    !(bus.rd_mem && bus.wr_mem));

  a_rd_pulse: assert property (@(posedge clk) disable iff (reset)
    bus.rd_mem |=> !bus.rd_mem);

  a_wr_pulse: assert property (@(posedge clk) disable iff (reset)
    bus.wr_mem |=> !bus.wr_mem);

  a_rdata_hold: assert property (@(posedge clk) disable iff (reset)
    (bus.rdata_valid && !bus.rdata_ready) |=> $stable(bus.rdata));

  a_rvalid_hold: assert property (@(posedge clk) disable iff (reset)
    (bus.rdata_valid && !bus.rdata_ready && bus.ready_mem) |=> bus.rdata_valid);

endmodule

// File: tb/tb_mem_requester.sv
// tb_mem_requester
//   Self-checking bench for mem_requester: a behavioural memory model, a
//   write-data driver, a read-data consumer with programmable stalls, and
//   scoreboards for memory strobes and returned read data.
module tb_mem_requester;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int LW = 4;

  logic clk;
  logic reset;
  logic busy;
  logic err;

  mem_requester_if #(.AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW)) bus ();

  mem_requester #(.AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW), .TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } strobe_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int            stall;
    int            exp_cycles;
    logic [DW-1:0] wbase;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  strobe_t       exp_str_q[$];
  logic [DW-1:0] exp_rd_q[$];
  logic [DW-1:0] wdata_q[$];

  logic stall_mode = 1'b0;
  int   cur_stall  = 0;
  int   wr_count   = 0;
  logic err_exp    = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pattern(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = pattern(i);
      ref_mem[i] = pattern(i);
    end
    mem[5]     = 32'hDEAD_BEEF;
    ref_mem[5] = 32'hDEAD_BEEF;
  end

  // Memory model: samples strobes on the falling edge, drops ready_mem while
  // strobed and, in stall mode, keeps it low to provoke a timeout.
  initial bus.ready_mem = 1'b1;
  initial bus.mem_data_rd = '0;
  always @(negedge clk) begin
    if (bus.rd_mem || bus.wr_mem) begin
      strobe_t e;
      check_output("strobe_exclusive", 32'(bus.rd_mem & bus.wr_mem), 32'd0);
      if (exp_str_q.size() == 0) begin
        check_output("unexpected_strobe_addr", 32'(bus.addr_mem), 32'hFFFF_FFFF);
      end else begin
        e = exp_str_q.pop_front();
        check_output("strobe_we", 32'(bus.wr_mem), 32'(e.we));
        check_output("strobe_addr", 32'(bus.addr_mem), 32'(e.addr));
        if (e.we) check_output("strobe_wdata", bus.mem_data_wr, e.data);
      end
      if (bus.rd_mem) begin
        bus.mem_data_rd = mem[bus.addr_mem];
      end else begin
        mem[bus.addr_mem] = bus.mem_data_wr;
        wr_count++;
      end
      bus.ready_mem = 1'b0;
    end else if (!stall_mode) begin
      bus.ready_mem = 1'b1;
    end
  end

  // Write-data driver: offers queued beats back-to-back.
  initial begin
    logic hs;
    bus.wdata       = '0;
    bus.wdata_valid = 1'b0;
    forever begin
      @(negedge clk);
      hs = bus.wdata_valid && bus.wdata_ready;
      @(posedge clk);
      #1;
      if (hs && wdata_q.size() > 0) void'(wdata_q.pop_front());
      bus.wdata_valid = (wdata_q.size() > 0);
      if (wdata_q.size() > 0) bus.wdata = wdata_q[0];
    end
  end

  // Read-data consumer: holds rdata_ready low for cur_stall cycles per beat.
  initial begin
    int stall_left;
    stall_left      = 0;
    bus.rdata_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bus.rdata_valid) begin
        if (stall_left > 0) begin
          bus.rdata_ready = 1'b0;
          stall_left--;
        end else begin
          bus.rdata_ready = 1'b1;
        end
      end else begin
        stall_left      = cur_stall;
        bus.rdata_ready = (cur_stall == 0);
      end
    end
  end

  // Read scoreboard and stall-stability monitor, sampled mid-cycle.
  initial begin
    logic          hold;
    logic [DW-1:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (hold && bus.rdata_valid) check_output("rdata_stable", bus.rdata, held);
        if (bus.rdata_valid && bus.rdata_ready) begin
          if (exp_rd_q.size() == 0) check_output("unexpected_rdata", bus.rdata, 32'hFFFF_FFFF);
          else check_output("rdata", bus.rdata, exp_rd_q.pop_front());
        end
        hold = bus.rdata_valid && !bus.rdata_ready;
        held = bus.rdata;
      end else begin
        hold = 1'b0;
      end
    end
  end

  task automatic wait_idle(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (busy && cycles < 300);
    if (busy) check_output("idle_wait_bound", 32'(busy), 32'd0);
  endtask

  task automatic push_cmd(input vec_t v, input logic track);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i <= int'(v.len); i++) begin
      a = v.addr + AW'(i);
      if (v.we) begin
        d = v.wbase + 32'(i);
        wdata_q.push_back(d);
        ref_mem[a] = d;
        exp_str_q.push_back('{1'b1, a, d});
      end else begin
        if (track) exp_rd_q.push_back(ref_mem[a]);
        exp_str_q.push_back('{1'b0, a, 32'h0});
      end
    end
  endtask

  task automatic apply_stimulus(input int idx, input vec_t v);
    int            cycles;
    logic [AW-1:0] a;
    cur_stall = v.stall;
    push_cmd(v, 1'b1);
    bus.cmd_we    = v.we;
    bus.cmd_addr  = v.addr;
    bus.cmd_len   = v.len;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    wait_idle(cycles);
    check_output($sformatf("v%0d_cycles", idx), 32'(cycles), 32'(v.exp_cycles));
    check_output($sformatf("v%0d_cmd_ready", idx), 32'(bus.cmd_ready), 32'd1);
    check_output($sformatf("v%0d_err", idx), 32'(err), 32'(err_exp));
    check_output($sformatf("v%0d_strobes_left", idx), 32'(exp_str_q.size()), 32'd0);
    check_output($sformatf("v%0d_rdata_left", idx), 32'(exp_rd_q.size()), 32'd0);
    if (v.we) begin
      for (int i = 0; i <= int'(v.len); i++) begin
        a = v.addr + AW'(i);
        check_output($sformatf("v%0d_mem_%0h", idx, a), mem[a], v.wbase + 32'(i));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_rd_mem"}, 32'(bus.rd_mem), 32'd0);
    check_output({tag, "_wr_mem"}, 32'(bus.wr_mem), 32'd0);
    check_output({tag, "_wdata_ready"}, 32'(bus.wdata_ready), 32'd0);
    check_output({tag, "_rdata_valid"}, 32'(bus.rdata_valid), 32'd0);
    check_output({tag, "_addr_mem"}, 32'(bus.addr_mem), 32'd0);
    check_output({tag, "_mem_data_wr"}, bus.mem_data_wr, 32'd0);
    check_output({tag, "_rdata"}, bus.rdata, 32'd0);
    check_output({tag, "_err"}, 32'(err), 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int cycles;
    int err_cycle;
    vec_t v;

    vecs[0] = '{1'b0, 9'h005, 4'd0,  0, 2,  32'h0};
    vecs[1] = '{1'b1, 9'h010, 4'd3,  0, 12, 32'hA0};
    vecs[2] = '{1'b0, 9'h1FE, 4'd2,  3, 15, 32'h0};
    vecs[3] = '{1'b0, 9'h010, 4'd3,  1, 12, 32'h0};
    vecs[4] = '{1'b1, 9'h1FF, 4'd1,  0, 6,  32'h5A5A_0100};
    vecs[5] = '{1'b0, 9'h1FF, 4'd1,  0, 4,  32'h0};
    vecs[6] = '{1'b0, 9'h100, 4'd15, 0, 32, 32'h0};

    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("post_rst");

    $display("[TB] table-driven command vectors");
    for (int i = 0; i < 7; i++) apply_stimulus(i, vecs[i]);

    $display("[TB] timeout sequence");
    stall_mode = 1'b1;
    cur_stall  = 100;
    v = '{1'b0, 9'h007, 4'd2, 0, 0, 32'h0};
    exp_str_q.push_back('{1'b0, 9'h007, 32'h0});
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = v.addr;
    bus.cmd_len   = v.len;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    cycles    = 0;
    err_cycle = -1;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      if (err && err_cycle < 0) err_cycle = cycles;
    end while (busy && cycles < 300);
    check_output("tmo_cycles", 32'(cycles), 32'd16);
    check_output("tmo_err_cycle", 32'(err_cycle), 32'd16);
    check_output("tmo_err", 32'(err), 32'd1);
    check_output("tmo_rdata_valid", 32'(bus.rdata_valid), 32'd0);
    check_output("tmo_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_output("tmo_strobes_left", 32'(exp_str_q.size()), 32'd0);
    stall_mode = 1'b0;
    cur_stall  = 0;
    err_exp    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    apply_stimulus(10, vecs[0]);

    $display("[TB] reset during second write beat");
    v = '{1'b1, 9'h040, 4'd3, 0, 0, 32'h7700_0000};
    for (int i = 0; i < 4; i++) wdata_q.push_back(v.wbase + 32'(i));
    exp_str_q.push_back('{1'b1, 9'h040, 32'h7700_0000});
    wr_count      = 0;
    bus.cmd_we    = 1'b1;
    bus.cmd_addr  = v.addr;
    bus.cmd_len   = v.len;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    cycles = 0;
    while (!(wr_count >= 1 && bus.wdata_ready) && cycles < 50) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check_output("mid_reach_beat1", 32'(cycles < 50), 32'd1);
    reset = 1'b1;
    wdata_q.delete();
    @(posedge clk);
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk);
    #1;
    reset   = 1'b0;
    err_exp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_output("mid_err", 32'(err), 32'd0);
    check_output("mid_wr_count", 32'(wr_count), 32'd1);
    check_output("mid_mem40", mem[9'h040], 32'h7700_0000);
    for (int i = 1; i < 4; i++)
      check_output($sformatf("mid_mem%0h", 9'h040 + i), mem[9'h040 + i], pattern(9'h040 + i));
    check_output("mid_strobes_left", 32'(exp_str_q.size()), 32'd0);

    $display("[TB] command gating with cmd_valid held high");
    cur_stall = 0;
    push_cmd('{1'b0, 9'h020, 4'd1, 0, 0, 32'h0}, 1'b1);
    push_cmd('{1'b0, 9'h030, 4'd1, 0, 0, 32'h0}, 1'b1);
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = 9'h020;
    bus.cmd_len   = 4'd1;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_addr = 9'h030;
    wait_idle(cycles);
    check_output("gate_first_cycles", 32'(cycles), 32'd4);
    check_output("gate_ready_after", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check_output("gate_reaccept_busy", 32'(busy), 32'd1);
    check_output("gate_reaccept_addr", 32'(bus.addr_mem), 32'h030);
    wait_idle(cycles);
    check_output("gate_second_cycles", 32'(cycles), 32'd4);
    check_output("gate_strobes_left", 32'(exp_str_q.size()), 32'd0);
    check_output("gate_rdata_left", 32'(exp_rd_q.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
